// File: rtl/heat_stencil_pipe.sv
// Three-stage 5-point heat-equation stencil update in signed fixed point.
// The stages are S1 Laplacian, S2 coef*lap scale, and S3 add/clamp. The whole pipe stalls together on output backpressure.
module heat_stencil_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 27,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] node_center,
  input  logic signed [WIDTH-1:0] node_up,
  input  logic signed [WIDTH-1:0] node_down,
  input  logic signed [WIDTH-1:0] node_left,
  input  logic signed [WIDTH-1:0] node_right,
  input  logic signed [WIDTH-1:0] coef,
  input  logic                    in_fixed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] new_center,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        sat_count,
  input  logic                    sat_clr
);

  localparam int STAGES = 3;
  localparam int LW = WIDTH + 3;
  localparam int PW = 2*WIDTH + 3;
  localparam int SW = 2*WIDTH + 4;

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;

  logic signed [LW-1:0]    lap_d, lap_q;
  logic signed [WIDTH-1:0] c1_d, c1_q, coef1_d, coef1_q;
  logic                    fix1_d, fix1_q;

  logic signed [PW-1:0]    sp2_d, sp2_q;
  logic signed [WIDTH-1:0] c2_d, c2_q;
  logic                    fix2_d, fix2_q;

  logic signed [WIDTH-1:0] out_d, out_q;
  logic                    sat_d, sat_q;
  logic [CNT_W-1:0]        sat_count_d, sat_count_q;

  logic                    advance, accept;
  logic signed [LW-1:0]    lap_calc;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    sum;
  logic [SW-WIDTH:0]       sum_hi;
  logic signed [WIDTH-1:0] res_calc;
  logic                    sat_calc;

  assign advance  = !vld_pipe_q[STAGES] | out_ready;
  // Report ready during reset too, but never accept while reset is high.
  assign in_ready = advance | reset;
  assign accept   = in_valid & advance & !reset;

  always_comb begin
    lap_calc = LW'(node_up) + LW'(node_down) + LW'(node_left) + LW'(node_right)
             - (LW'(node_center) <<< 2);
    prod     = PW'(coef1_q) * PW'(lap_q);
    sum      = SW'(c2_q) + SW'(sp2_q);
    sum_hi   = sum[SW-1:WIDTH-1];
    res_calc = sum[WIDTH-1:0];
    sat_calc = 1'b0;
    if (fix2_q) begin
      res_calc = c2_q;
    end else if (!((&sum_hi) | (~|sum_hi))) begin
      // The bits above the result sign disagree, so the sum overflowed: clamp toward its true sign.
      sat_calc = 1'b1;
      res_calc = sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    lap_d      = lap_q;
    c1_d       = c1_q;
    coef1_d    = coef1_q;
    fix1_d     = fix1_q;
    sp2_d      = sp2_q;
    c2_d       = c2_q;
    fix2_d     = fix2_q;
    out_d      = out_q;
    sat_d      = sat_q;
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      lap_d      = lap_calc;
      c1_d       = node_center;
      coef1_d    = coef;
      fix1_d     = in_fixed;
      sp2_d      = prod >>> FRAC;
      c2_d       = c1_q;
      fix2_d     = fix1_q;
      if (vld_pipe_q[STAGES-1]) begin
        out_d = res_calc;
        sat_d = sat_calc;
      end
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr)
      sat_count_d = '0;
    else if (vld_pipe_q[STAGES] & out_ready & sat_q & ~&sat_count_q)
      sat_count_d = sat_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      lap_q       <= '0;
      c1_q        <= '0;
      coef1_q     <= '0;
      fix1_q      <= 1'b0;
      sp2_q       <= '0;
      c2_q        <= '0;
      fix2_q      <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      sat_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      lap_q       <= lap_d;
      c1_q        <= c1_d;
      coef1_q     <= coef1_d;
      fix1_q      <= fix1_d;
      sp2_q       <= sp2_d;
      c2_q        <= c2_d;
      fix2_q      <= fix2_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid  = vld_pipe_q[STAGES];
  assign new_center = out_q;
  assign out_sat    = sat_q;
  assign sat_count  = sat_count_q;

endmodule
